// File: rtl/rr_arbiter4_pkg.sv
// arb_pkg: shared sizing, state type and counter-width helper for rr_arbiter4
package arb_pkg;
    localparam int N = 4;
    localparam int IDX_W = 2;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    function automatic int hold_w(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set candidate bit scanning upward from ptr, wrapping N-1 to 0
module rr_priority_pick import arb_pkg::*; (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N-1:0] rot;
    logic [IDX_W-1:0] idx_r;
    assign rot = N'({cand, cand} >> ptr);
    always_comb begin
        idx_r = '0;
        for (int i = N - 1; i >= 0; i--) idx_r = rot[i] ? IDX_W'(i) : idx_r;
    end
    assign idx = idx_r + ptr;
    assign any = |cand;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter, grant held while requested, tenure capped at MAX_HOLD
module rr_arbiter4 import arb_pkg::*; #(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             preempt
);
    localparam int HW = hold_w(MAX_HOLD);
    arb_state_t state;
    logic [IDX_W-1:0] ptr, pick_ptr, pick_idx, win;
    logic [HW-1:0] hold_cnt;
    logic [N-1:0] cand;
    logic owned, drop, expire, pick_any;
    assign owned = state == GRANT;
    assign drop = owned && !req[grant_idx];
    assign expire = owned && req[grant_idx] && hold_cnt == HW'(MAX_HOLD - 1);
    // on expiry others go first; the owner is regranted only when nobody else waits
    assign cand = expire ? req & ~grant : req;
    assign pick_ptr = owned ? grant_idx + IDX_W'(1) : ptr;
    assign win = pick_any ? pick_idx : grant_idx;
    rr_priority_pick u_pick (
        .cand(cand),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            preempt <= expire;
            if (!owned || drop || expire) begin
                if (owned) ptr <= pick_ptr;
                hold_cnt <= '0;
                if (pick_any || expire) begin
                    state       <= GRANT;
                    grant_idx   <= win;
                    grant       <= N'(1) << win;
                    grant_valid <= 1'b1;
                end else begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                end
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: scoreboard-driven bench for rr_arbiter4 with directed scenarios and random invariants
module tb_rr_arbiter4;
    localparam int MAX_HOLD = 8;
    typedef struct packed {
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       p;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic grant_valid, preempt;
    exp_t sb[$];
    exp_t mon_e;
    int n_tests = 0;
    int n_fail = 0;
    bit m_valid;
    int m_owner, m_ptr, m_hold;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .preempt    (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // reference arbiter: computes the outputs expected after the next rising edge
    task automatic model_step(input logic [3:0] r);
        logic [3:0] c;
        bit pre, found;
        int w;
        pre = m_valid && r[m_owner] && m_hold == MAX_HOLD - 1;
        found = 0;
        w = 0;
        if (m_valid && r[m_owner] && !pre) m_hold++;
        else begin
            if (m_valid) m_ptr = (m_owner + 1) % 4;
            c = r;
            if (pre) c[m_owner] = 1'b0;
            for (int k = 0; k < 4; k++)
                if (!found && c[(m_ptr + k) % 4]) begin
                    found = 1;
                    w = (m_ptr + k) % 4;
                end
            if (pre && !found) begin
                found = 1;
                w = m_owner;
            end
            m_hold = 0;
            m_valid = found;
            if (found) m_owner = w;
        end
        sb.push_back('{g: m_valid ? 4'(1 << m_owner) : 4'b0, idx: 2'(m_owner), v: m_valid, p: pre});
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_owner = 0;
        m_ptr = 0;
        m_hold = 0;
        sb.delete();
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        model_step(r);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (grant !== mon_e.g || grant_valid !== mon_e.v || preempt !== mon_e.p ||
                (mon_e.v && grant_idx !== mon_e.idx)) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got grant=%b idx=%0d valid=%b preempt=%b, expected grant=%b idx=%0d valid=%b preempt=%b",
                         $time, grant, grant_idx, grant_valid, preempt, mon_e.g, mon_e.idx, mon_e.v, mon_e.p);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        #22;
        n_tests++;
        if (grant !== 4'b0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_grant: got grant=%b valid=%b, expected 0000/0", grant, grant_valid);
        end
        n_tests++;
        if (grant_idx !== 2'd0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idx: got idx=%0d preempt=%b, expected 0/0", grant_idx, preempt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_handover();
        step(4'b1010);
        n_tests++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got grant=%b idx=%0d valid=%b, expected 0010/1/1", grant, grant_idx, grant_valid);
        end
        step(4'b1000);
        n_tests++;
        if (grant !== 4'b1000 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL handover: got grant=%b valid=%b, expected 1000/1", grant, grant_valid);
        end
        step(4'b0000);
        n_tests++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: got grant=%b valid=%b, expected 0000/0", grant, grant_valid);
        end
    endtask

    task automatic test_single_hold();
        apply_reset();
        for (int k = 1; k <= 25; k++) begin
            step(4'b0001);
            n_tests++;
            if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL single_hold cyc %0d: got grant=%b valid=%b, expected 0001/1", k, grant, grant_valid);
            end
            n_tests++;
            if (preempt !== 1'((k > 1) && ((k - 1) % MAX_HOLD == 0))) begin
                n_fail++;
                $display("FAIL single_preempt cyc %0d: got %b, expected %b", k, preempt, (k > 1) && ((k - 1) % MAX_HOLD == 0));
            end
        end
        step(4'b0000);
    endtask

    task automatic test_two_hold();
        apply_reset();
        for (int k = 1; k <= 24; k++) begin
            step(4'b0011);
            n_tests++;
            if (grant_idx !== 2'(((k - 1) / MAX_HOLD) % 2) || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL two_hold cyc %0d: got idx=%0d valid=%b, expected %0d/1", k, grant_idx, grant_valid, ((k - 1) / MAX_HOLD) % 2);
            end
            n_tests++;
            if (preempt !== 1'((k > 1) && ((k - 1) % MAX_HOLD == 0))) begin
                n_fail++;
                $display("FAIL two_preempt cyc %0d: got %b, expected %b", k, preempt, (k > 1) && ((k - 1) % MAX_HOLD == 0));
            end
        end
        step(4'b0000);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(4'b1111);
        for (int o = 0; o < 4; o++) begin
            n_tests++;
            if (grant_idx !== 2'(o) || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_order tenure %0d: got idx=%0d valid=%b, expected %0d/1", o, grant_idx, grant_valid, o);
            end
            step(4'b1111);
            n_tests++;
            if (grant_idx !== 2'(o) || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_hold tenure %0d: got idx=%0d preempt=%b, expected %0d/0", o, grant_idx, preempt, o);
            end
            step(4'b1111 & ~(4'(1) << o));
        end
        n_tests++;
        if (grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_wrap: got idx=%0d valid=%b, expected 0/1", grant_idx, grant_valid);
        end
        step(4'b0000);
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(4'b0100);
        step(4'b0100);
        n_tests++;
        if (grant_idx !== 2'd2 || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL pre_reset_owner: got idx=%0d grant=%b, expected 2/0100", grant_idx, grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (grant !== 4'b0 || grant_idx !== 2'd0 || grant_valid !== 1'b0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: got grant=%b idx=%0d valid=%b preempt=%b, expected all 0", grant, grant_idx, grant_valid, preempt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110);
        n_tests++;
        if (grant_idx !== 2'd1 || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_ptr: got idx=%0d grant=%b, expected 1/0010", grant_idx, grant);
        end
        step(4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        int waits[4];
        int ten;
        logic prev_v;
        logic [1:0] prev_idx;
        apply_reset();
        r = '0;
        ten = 0;
        prev_v = 1'b0;
        prev_idx = '0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
            step(r);
            n_tests++;
            if (!$onehot0(grant)) begin
                n_fail++;
                $display("FAIL onehot cyc %0d: got grant=%b, expected one-hot or zero", c, grant);
            end
            n_tests++;
            if (grant_valid !== (|grant) || (grant_valid && grant !== 4'(1) << grant_idx)) begin
                n_fail++;
                $display("FAIL consistency cyc %0d: got grant=%b idx=%0d valid=%b, expected grant=1<<idx and valid=|grant", c, grant, grant_idx, grant_valid);
            end
            if (!grant_valid) ten = 0;
            else if (!prev_v || grant_idx != prev_idx || preempt) ten = 1;
            else ten++;
            prev_v = grant_valid;
            prev_idx = grant_idx;
            n_tests++;
            if (ten > MAX_HOLD) begin
                n_fail++;
                $display("FAIL tenure cyc %0d: got length %0d, expected <= %0d", c, ten, MAX_HOLD);
            end
            for (int i = 0; i < 4; i++) begin
                waits[i] = (r[i] && !grant[i]) ? waits[i] + 1 : 0;
                n_tests++;
                if (waits[i] > 3 * MAX_HOLD + 1) begin
                    n_fail++;
                    $display("FAIL starvation cyc %0d req %0d: got wait %0d, expected <= %0d", c, i, waits[i], 3 * MAX_HOLD + 1);
                end
            end
        end
        step(4'b0000);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_handover();
        test_single_hold();
        test_two_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter that shares one downstream resource among four requesters. It uses a rotating-priority pick to grant exactly one requester at a time and holds the grant while that requester keeps its request asserted. A bounded tenure counter forces preemption so no requester can starve the others. It sits between the requester-side request lines and the shared datapath, which consumes the one-hot grant or the encoded index.

## Interface
- `N`, default 4: number of requesters. Fixed at 4 for this block.
- `IDX_W`, default 2: width of the encoded grant index.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure. Must be ≥ 1.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset. Asynchronous, active-low.
- `req`  in  4  — request lines, one per requester. Level-sensitive. A requester holds its line high for the whole tenure it wants.
- `grant`  out  4  — one-hot grant. Registered.
- `grant_idx`  out  2  — encoded index of the owner. Valid only when `grant_valid` is high.
- `grant_valid`  out  1  — high when some requester owns the resource.
- `preempt`  out  1  — one-cycle pulse, asserted the cycle after a tenure ends by expiry.

## Operation
- Reset values:
  - `grant`=0, `grant_idx`=0, `grant_valid`=0, `preempt`=0.
  - Pointer `ptr`=0, `hold_cnt`=0, state IDLE.
- States:
  - IDLE: no owner.
  - GRANT: owner held in `grant_idx`.
- Pick function: the winner is the first set bit of the candidate vector, scanning upward from `ptr` and wrapping 3→0.
- IDLE:
  - If `req`≠0, pick from `req`, go to GRANT, set `hold_cnt`=0.
  - Otherwise stay in IDLE.
- GRANT, release by drop: `req[owner]`=0.
  - Set `ptr` = owner+1 mod 4.
  - Pick from `req` in the same cycle. If a winner exists, grant it back-to-back and reset `hold_cnt`. Otherwise go to IDLE.
- GRANT, expiry: `req[owner]`=1 and `hold_cnt`=MAX_HOLD−1.
  - Set `ptr` = owner+1 mod 4 and pulse `preempt` next cycle.
  - Pick from `req` with the owner masked out. If no other requester is pending, regrant the owner with `hold_cnt` reset, and still pulse `preempt`.
- GRANT, otherwise: keep the owner and increment `hold_cnt`.
- `ptr` changes only on release or expiry, never in IDLE.
- Request changes by non-owners during a tenure have no effect on the current grant.
- Invariants:
  - `grant` is one-hot or zero.
  - `grant` = 1<<`grant_idx` whenever `grant_valid`=1.
  - `grant_valid` = |`grant`.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge t, grant visible after edge t.
- Release latency is 1 cycle: `req[owner]` falling sampled at edge t, grant removed or handed over after edge t.
- Handover has no bubble.
- A tenure lasts at most MAX_HOLD cycles of `grant_valid` for one owner before preemption is evaluated.
- Requests rising in the same cycle are resolved purely by `ptr` order.
- A drop and an expiry in the same cycle cannot coincide, because expiry requires `req[owner]`=1.
- If `rst_n` falls mid-tenure, all state and outputs clear immediately (asynchronous). The first grant after reset scans from index 0.
- `hold_cnt` is wide enough for MAX_HOLD−1 and never wraps.

## Structure
- Package `arb_pkg` holds:
  - `N`, `IDX_W`.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - A helper constant for the `hold_cnt` width, $clog2(MAX_HOLD).
- Sub-module `rr_priority_pick`: purely combinational.
  - Inputs: 4-bit candidate vector, 2-bit `ptr`.
  - Outputs: 2-bit index and `any`.
  - Built as rotate → fixed priority encoder → un-rotate.
- The top level holds the FSM, pointer, counter and output registers.

## Test plan
- Reset, then `req`=4'b1010 → next cycle `grant`=4'b0010, `grant_idx`=1, `grant_valid`=1. Drop `req[1]` (`req`=4'b1000) → next cycle `grant`=4'b1000, with no idle cycle between grants.
- `req`=4'b0001 held, MAX_HOLD=8 → `grant`=4'b0001 stays continuous, `preempt` pulses every 8 cycles, `grant_valid` never drops.
- `req`=4'b0011 held, MAX_HOLD=8 → owner 0 for 8 cycles, then owner 1 for 8 cycles, then owner 0; `preempt` pulses at each handover.
- All four requesting from reset, each dropping after 2 grant cycles and re-raising → grant order 0,1,2,3,0; each tenure lasts 2 cycles.
- Assert `rst_n`=0 mid-tenure while owner=2 → all outputs are 0 immediately. Release reset with `req`=4'b0110 → next grant is index 1, because `ptr` was reset to 0.
- Random `req` for 10k cycles → check invariants every cycle: one-hot, index/grant consistency, no tenure longer than MAX_HOLD, and each pending requester granted within 3·MAX_HOLD+1 cycles.
